// File: rtl/ser_pkg.sv
// Shared types for the bit serializer front end.
// State encoding and frame-length helper used by bit_serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_PAR   = 2'b10
    } ser_state_t;

    function automatic int ser_frame_len(input int width,
                                         input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register; presents the head bit of the loaded word.
// SER_PARITY_EN adds a parity register fed back as the fill bit.
module ser_shift_reg
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
`ifdef SER_PARITY_EN
    output logic             parity_o,
`endif
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Fill bits reach the head after WIDTH shifts, i.e. right after the last data bit
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            if (LSB_FIRST) begin
                sr_d = {fill_i, sr_q[WIDTH-1:1]};
            end else begin
                sr_d = {sr_q[WIDTH-2:0], fill_i};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

`ifdef SER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^data_i;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// Define SER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_en,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_data,
    output logic                       load_ready,
    output logic                       x_out,
    output logic                       x_valid,
    output logic                       frame_start,
    output logic                       frame_end,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int N = ser_frame_len(WIDTH, PAR_EN);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    ser_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic            xv_q;
    logic            fs_q;
    logic            fe_q;

    logic            busy;
    logic            last;
    logic            strobe_last;
    logic            accept;
    logic            sr_load;
    logic            sr_shift;
    logic            fill;
    logic [WIDTH-1:0] sr_data;

    assign busy        = (state_q != S_IDLE);
    assign last        = busy && (cnt_q == LAST);
    assign strobe_last = bit_en & last;
    assign load_ready  = ~busy | strobe_last;
    assign accept      = load_valid & load_ready;

    // Leaving a frame without a new word reloads zeros so x_out idles low
    assign sr_load  = accept | strobe_last;
    assign sr_shift = bit_en & busy & ~last;
    assign sr_data  = accept ? load_data : '0;

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_sr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (sr_load),
        .shift_i  (sr_shift),
        .data_i   (sr_data),
        .fill_i   (fill),
`ifdef SER_PARITY_EN
        .parity_o (fill),
`endif
        .bit_o    (x_out)
    );

`ifndef SER_PARITY_EN
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else if (accept) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            xv_q    <= 1'b1;
            fs_q    <= 1'b1;
            fe_q    <= 1'b0;
        end else if (strobe_last) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else if (sr_shift) begin
            cnt_q <= cnt_q + CW'(1);
            fs_q  <= 1'b0;
            fe_q  <= ((cnt_q + CW'(1)) == LAST);
`ifdef SER_PARITY_EN
            if (cnt_q == LAST_DATA) begin
                state_q <= S_PAR;
            end
`endif
        end
    end

    assign x_valid     = xv_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign bit_cnt     = cnt_q;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence detector FSM.
- Accepts one WIDTH-bit word per valid/ready handshake and shifts it out one bit per bit_en strobe on x_out.
- x_out drives the detector's x_in directly, and x_valid qualifies it.
- Optionally appends an even-parity bit to each frame.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..32.
- LSB_FIRST, 0: 0 sends MSB first; 1 sends LSB first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bit_en  in  1  bit-rate strobe; the serial stream advances only on edges where bit_en=1.
- load_valid  in  1  load_data is valid.
- load_data  in  WIDTH  word to serialize.
- load_ready  out  1  block can accept a word this cycle (combinational).
- x_out  out  1  current serial bit (registered).
- x_valid  out  1  x_out holds a frame bit (registered).
- frame_start  out  1  the first bit of a frame is on x_out (registered).
- frame_end  out  1  the last bit of a frame is on x_out (registered).
- bit_cnt  out  $clog2(WIDTH+1)  index of the bit currently on x_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, bit_cnt, x_out, x_valid, frame_start and frame_end all go to 0.
  - load_ready=1 once rst releases.
- States: IDLE, SHIFT, PAR. PAR exists only with the optional feature.
- Frame length N = WIDTH, or WIDTH+1 with parity.
- load_ready = (state==IDLE) | (bit_en & last bit on x_out).
- Accept = load_valid & load_ready at a rising edge. Accept does not depend on bit_en while in IDLE.
- IDLE, on accept:
  - Capture load_data and go to SHIFT.
  - Next cycle: x_out = first bit (MSB, or LSB if LSB_FIRST), x_valid=1, frame_start=1, bit_cnt=0.
  - Latency from accept edge to first bit on x_out is one cycle.
- SHIFT:
  - bit_en=0: all outputs hold; no shift.
  - bit_en=1, not last: present the next bit, bit_cnt+1, frame_start=0.
  - frame_end=1 exactly while bit_cnt==N-1.
- Last bit with bit_en=1:
  - load_valid=1: accept a new word back-to-back. Next cycle shows its first bit with frame_start=1. No idle gap.
  - load_valid=0: go to IDLE; x_valid, frame_start, frame_end, x_out and bit_cnt go to 0.
- load_valid while busy and not on the last-bit strobe: not accepted, load_ready=0. The upstream source must hold the word.
- Reset mid-frame: partial frame is discarded; no further bits are emitted.
- bit_en asserted while in IDLE: ignored.
- Unused shift-register bits are don't-care. Only the presented bit is observable.
- With WIDTH=2 and bit_en tied high, a frame lasts two cycles.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After data bit WIDTH-1 is strobed, enter PAR.
  - x_out = XOR of all WIDTH data bits (even parity); bit_cnt=WIDTH; frame_end=1.
  - Back-to-back and IDLE exits occur from PAR instead of SHIFT.
  - The last data bit has frame_end=0.
- Undefined:
  - PAR state and parity logic are absent.
  - frame_end marks data bit WIDTH-1.

Decomposition:
- Shared package ser_pkg:
  - state enum ser_state_t {S_IDLE=2'b00, S_SHIFT=2'b01, S_PAR=2'b10}.
  - function ser_frame_len(width, parity_en).
- One natural sub-module, ser_shift_reg:
  - WIDTH-wide loadable shift register with a direction parameter.
  - Outputs the current bit and the parity of the loaded word.
- The FSM and counter stay in bit_serializer.

Test Plan:
- Reset then single word: rst low 3 cycles, bit_en=1, load 8'hA5, LSB_FIRST=0.
  - Expect x_out 1,0,1,0,0,1,0,1 on consecutive cycles after accept.
  - frame_start on bit 0 only; frame_end on bit 7 only; x_valid drops the cycle after.
- Paced output: bit_en every 4th cycle, load 8'h0F.
  - Each bit is held exactly 4 cycles; bit_cnt 0..7; load_ready=0 throughout.
- Back-to-back: load_valid held high with 8'hFF then 8'h00.
  - 16 contiguous x_valid cycles; second frame_start falls immediately after the first frame_end.
- LSB_FIRST=1, load 8'h01: x_out 1 then seven 0s.
- Reset mid-frame: assert rst at bit 3 of 8'hC3.
  - Outputs go to 0 immediately without waiting for clk; after release, IDLE with load_ready=1 and no residual bits.
- SER_PARITY_EN, load 8'h07: 9 bits; parity bit = 1; frame_end on bit_cnt=8 only.
  - Load 8'h03: parity bit = 0.
